// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   boot_state_e   : loader FSM state encoding
//   BOOT_HDR_BYTES : header length in bytes (little-endian word count)
//   BYTES_PER_WORD : bytes assembled per instruction word
package boot_pkg;

  typedef enum logic [2:0] {
    StHdr0,
    StHdr1,
    StData,
    StWrite,
    StDone,
    StError
  } boot_state_e;

  localparam int unsigned BOOT_HDR_BYTES = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_timeout_timer.sv
// Idle-cycle watchdog for the boot loader.
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : zero the counter (has priority over enable_i)
//   enable_i      : count this cycle
//   expire_o      : this cycle's increment takes the count to TIMEOUT_CYCLES-1
module boot_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Flag on the edge that would land on TIMEOUT_CYCLES-1 so the FSM's
  // registered error output appears in that same cycle.
  assign expire_o = enable_i & ~clear_i & (cnt_q == CntW'(TIMEOUT_CYCLES - 2));

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a byte stream, assembles little-endian 32-bit words and
// writes them into instruction memory, holding the CPU in reset until done.
//   clk_i, rst_ni      : clock, async active-low reset
//   rx_valid_i/data_i  : incoming byte, consumed when rx_valid_i & rx_ready_o
//   rx_ready_o         : loader accepts a byte this cycle
//   load_we_o/addr_o/data_o : one-cycle imem write per assembled word
//   cpu_reset_o        : processor reset, released after the image is written
//   busy_o             : loader owns the imem port
//   done_o, error_o    : sticky completion / failure flags
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned MAX_WORDS      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_data_i,
  output logic                  rx_ready_o,
  output logic                  load_we_o,
  output logic [ADDR_WIDTH-1:0] load_addr_o,
  output logic [31:0]           load_data_o,
  output logic                  cpu_reset_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int unsigned HdrBits = 8 * BOOT_HDR_BYTES;

  boot_state_e           state_q;
  logic [HdrBits-1:0]    count_q;
  logic [ADDR_WIDTH:0]   word_idx_q;  // one extra bit so N == 2**ADDR_WIDTH cannot wrap
  logic [1:0]            byte_idx_q;
  logic [31:0]           word_q;
  logic                  rx_ready_q;
  logic                  load_we_q;
  logic [ADDR_WIDTH-1:0] load_addr_q;
  logic [31:0]           load_data_q;
  logic                  cpu_reset_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;

  logic               xfer;
  logic               in_wait;
  logic               tmo;
  logic [HdrBits-1:0] n_full;
  logic               hdr_bad;
  logic               last_word;
  logic [31:0]        word_next;

  assign xfer      = rx_valid_i & rx_ready_q;
  assign in_wait   = (state_q == StHdr1) || (state_q == StData);
  assign n_full    = {rx_data_i, count_q[7:0]};
  assign hdr_bad   = (n_full == '0) || (n_full > HdrBits'(MAX_WORDS));
  assign last_word = (32'(word_idx_q) + 32'd1) == 32'(count_q);
  assign word_next = {rx_data_i, word_q[31:8]};

  boot_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (xfer | ~in_wait),
    .enable_i(in_wait & ~xfer),
    .expire_o(tmo)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StHdr0;
      count_q     <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      rx_ready_q  <= 1'b0;
      load_we_q   <= 1'b0;
      load_addr_q <= '0;
      load_data_q <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      load_we_q <= 1'b0;
      unique case (state_q)
        StHdr0: begin
          rx_ready_q <= 1'b1;
          if (xfer) begin
            count_q[7:0] <= rx_data_i;
            state_q      <= StHdr1;
          end
        end
        StHdr1: begin
          if (xfer) begin
            count_q <= n_full;
            state_q <= hdr_bad ? StError : StData;
          end else if (tmo) begin
            state_q <= StError;
          end
          if ((xfer && hdr_bad) || (!xfer && tmo)) begin
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b1;
          end
        end
        StData: begin
          if (xfer) begin
            word_q     <= word_next;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'(BYTES_PER_WORD - 1)) begin
              // Write strobe is registered so it lines up with the WRITE state.
              state_q     <= StWrite;
              rx_ready_q  <= 1'b0;
              load_we_q   <= 1'b1;
              load_addr_q <= word_idx_q[ADDR_WIDTH-1:0];
              load_data_q <= word_next;
            end
          end else if (tmo) begin
            state_q    <= StError;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b1;
          end
        end
        StWrite: begin
          if (last_word) begin
            state_q     <= StDone;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b0;
          end else begin
            word_idx_q <= word_idx_q + 1'b1;
            state_q    <= StData;
            rx_ready_q <= 1'b1;
          end
        end
        StDone, StError: begin
          rx_ready_q <= 1'b0;
        end
        default: begin
          state_q    <= StError;
          rx_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          error_q    <= 1'b1;
        end
      endcase
    end
  end

  assign rx_ready_o  = rx_ready_q;
  assign load_we_o   = load_we_q;
  assign load_addr_o = load_addr_q;
  assign load_data_o = load_data_q;
  assign cpu_reset_o = cpu_reset_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;

endmodule
